// File: rtl/sccb_init_seq.sv
// Walks a register table and issues one 2-byte SCCB write per entry to the I2C master.
// Entry FF = end of table, FE = delay of val ms, anything else = write {reg, val}.
module sccb_init_seq #(
    parameter logic [6:0]  DEV_ADR     = 7'h21,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned CLK_PER_MS  = 50000,
    parameter int unsigned GAP_CYCLES  = 200,
    parameter int unsigned ACK_TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              start,
    output logic [ADDR_W-1:0] tbl_addr,
    input  logic [15:0]       tbl_data,
    output logic [6:0]        i2c_adr,
    output logic              i2c_wr,
    output logic              i2c_rd,
    output logic [31:0]       i2c_wr_data,
    output logic [2:0]        i2c_wr_bytes,
    input  logic              i2c_busy,
    output logic              run,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] wr_count
);
    localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned CycW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam int unsigned AckW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    localparam logic [GapW-1:0] GapLast = GapW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [CycW-1:0] CycLast = CycW'((CLK_PER_MS > 0) ? CLK_PER_MS - 1 : 0);
    // First ms is shortened to absorb the FETCH/DECODE/ISSUE overhead around a delay.
    localparam logic [CycW-1:0] CycBias = CycW'((CLK_PER_MS > 3) ? 3 : 0);
    localparam logic [AckW-1:0] AckLast = AckW'((ACK_TIMEOUT > 1) ? ACK_TIMEOUT - 2 : 0);

    typedef enum logic [3:0] {
        StIdle, StFetch, StDecode, StIssue, StWaitAck,
        StWaitDone, StGap, StDelay, StFin, StErr
    } state_e;

    state_e            r_state, w_state_nxt;
    logic              r_start_q;
    logic [ADDR_W-1:0] r_tbl_addr, w_tbl_addr_nxt;
    logic [ADDR_W-1:0] r_wr_count, w_wr_count_nxt;
    logic [31:0]       r_wr_data, w_wr_data_nxt;
    logic [AckW-1:0]   r_ack_cnt, w_ack_cnt_nxt;
    logic [GapW-1:0]   r_gap_cnt, w_gap_cnt_nxt;
    logic [7:0]        r_ms_cnt, w_ms_cnt_nxt;
    logic [CycW-1:0]   r_cyc_cnt, w_cyc_cnt_nxt;
    logic              w_advance;
    logic              w_start_rise;

    assign w_start_rise = start & ~r_start_q;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state    <= StIdle;
            r_start_q  <= 1'b0;
            r_tbl_addr <= '0;
            r_wr_count <= '0;
            r_wr_data  <= '0;
            r_ack_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_ms_cnt   <= '0;
            r_cyc_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_start_q  <= start;
            r_tbl_addr <= w_tbl_addr_nxt;
            r_wr_count <= w_wr_count_nxt;
            r_wr_data  <= w_wr_data_nxt;
            r_ack_cnt  <= w_ack_cnt_nxt;
            r_gap_cnt  <= w_gap_cnt_nxt;
            r_ms_cnt   <= w_ms_cnt_nxt;
            r_cyc_cnt  <= w_cyc_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_tbl_addr_nxt = r_tbl_addr;
        w_wr_count_nxt = r_wr_count;
        w_wr_data_nxt  = r_wr_data;
        w_ack_cnt_nxt  = r_ack_cnt;
        w_gap_cnt_nxt  = r_gap_cnt;
        w_ms_cnt_nxt   = r_ms_cnt;
        w_cyc_cnt_nxt  = r_cyc_cnt;
        w_advance      = 1'b0;
        case (r_state)
            StIdle, StFin, StErr: begin
                if (w_start_rise) begin
                    w_tbl_addr_nxt = '0;
                    w_wr_count_nxt = '0;
                    w_state_nxt    = StFetch;
                end
            end
            StFetch: w_state_nxt = StDecode;
            StDecode: begin
                if (tbl_data[15:8] == 8'hFF) begin
                    w_state_nxt = StFin;
                end else if (tbl_data[15:8] == 8'hFE) begin
                    if (tbl_data[7:0] == 8'h00) begin
                        w_advance = 1'b1;
                    end else begin
                        w_ms_cnt_nxt  = tbl_data[7:0];
                        w_cyc_cnt_nxt = CycBias;
                        w_state_nxt   = StDelay;
                    end
                end else begin
                    w_wr_data_nxt = {tbl_data, 16'h0000};
                    w_state_nxt   = StIssue;
                end
            end
            StIssue: begin
                w_wr_count_nxt = r_wr_count + ADDR_W'(1);
                w_ack_cnt_nxt  = '0;
                w_state_nxt    = StWaitAck;
            end
            StWaitAck: begin
                if (i2c_busy) begin
                    w_state_nxt = StWaitDone;
                end else if (r_ack_cnt == AckLast) begin
                    w_state_nxt = StErr;
                end else begin
                    w_ack_cnt_nxt = r_ack_cnt + AckW'(1);
                end
            end
            StWaitDone: begin
                if (!i2c_busy) begin
                    w_gap_cnt_nxt = '0;
                    w_state_nxt   = StGap;
                end
            end
            StGap: begin
                if (r_gap_cnt == GapLast) w_advance = 1'b1;
                else                      w_gap_cnt_nxt = r_gap_cnt + GapW'(1);
            end
            StDelay: begin
                if (r_cyc_cnt == CycLast) begin
                    w_cyc_cnt_nxt = '0;
                    w_ms_cnt_nxt  = r_ms_cnt - 8'd1;
                    if (r_ms_cnt == 8'd1) w_advance = 1'b1;
                end else begin
                    w_cyc_cnt_nxt = r_cyc_cnt + CycW'(1);
                end
            end
            default: w_state_nxt = StIdle;
        endcase
        if (w_advance) begin
            if (&r_tbl_addr) begin
                w_state_nxt = StFin;
            end else begin
                w_tbl_addr_nxt = r_tbl_addr + ADDR_W'(1);
                w_state_nxt    = StFetch;
            end
        end
    end

    assign tbl_addr     = r_tbl_addr;
    assign wr_count     = r_wr_count;
    assign i2c_wr_data  = r_wr_data;
    assign i2c_wr       = (r_state == StIssue);
    assign i2c_adr      = DEV_ADR;
    assign i2c_rd       = 1'b0;
    assign i2c_wr_bytes = 3'd2;
    assign done         = (r_state == StFin);
    assign err          = (r_state == StErr);
    assign run          = !(r_state inside {StIdle, StFin, StErr});

endmodule

// File: tb/tb_sccb_init_seq.sv
// Randomised bench for sccb_init_seq: ROM and I2C master models plus a table-walk
// reference that predicts the write stream, end address and timing bounds.
module tb_sccb_init_seq;
    localparam int unsigned AW   = 8;
    localparam int unsigned CPM  = 10;
    localparam int unsigned GAP  = 20;
    localparam int unsigned ACKT = 4;

    logic          clk = 1'b0;
    logic          rstb = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] tbl_addr;
    logic [15:0]   tbl_data;
    logic [6:0]    i2c_adr;
    logic          i2c_wr;
    logic          i2c_rd;
    logic [31:0]   i2c_wr_data;
    logic [2:0]    i2c_wr_bytes;
    logic          i2c_busy;
    logic          run;
    logic          done;
    logic          err;
    logic [AW-1:0] wr_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;

    logic [15:0] rom [256];
    logic [31:0] pulse_q[$];
    int          pulse_cyc_q[$];
    int          fall_q[$];
    logic [31:0] exp_q[$];
    int          exp_end;
    bit          busy_never = 1'b0;
    int          busy_len = 5;
    int          busy_left = 0;
    logic        busy_prev = 1'b0;

    sccb_init_seq #(
        .DEV_ADR    (7'h21),
        .ADDR_W     (AW),
        .CLK_PER_MS (CPM),
        .GAP_CYCLES (GAP),
        .ACK_TIMEOUT(ACKT)
    ) u_dut (
        .clk         (clk),
        .rstb        (rstb),
        .start       (start),
        .tbl_addr    (tbl_addr),
        .tbl_data    (tbl_data),
        .i2c_adr     (i2c_adr),
        .i2c_wr      (i2c_wr),
        .i2c_rd      (i2c_rd),
        .i2c_wr_data (i2c_wr_data),
        .i2c_wr_bytes(i2c_wr_bytes),
        .i2c_busy    (i2c_busy),
        .run         (run),
        .done        (done),
        .err         (err),
        .wr_count    (wr_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) tbl_data <= rom[tbl_addr];

    // Master model: busy rises the cycle after a wr pulse and stays high busy_len cycles.
    always @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            i2c_busy  <= 1'b0;
            busy_left <= 0;
        end else if (i2c_wr && !busy_never) begin
            i2c_busy  <= 1'b1;
            busy_left <= busy_len;
        end else if (busy_left > 1) begin
            busy_left <= busy_left - 1;
        end else begin
            i2c_busy  <= 1'b0;
            busy_left <= 0;
        end
    end

    always @(negedge clk) begin
        if (i2c_wr) begin
            pulse_q.push_back(i2c_wr_data);
            pulse_cyc_q.push_back(cyc);
        end
        if (busy_prev && !i2c_busy) fall_q.push_back(cyc);
        busy_prev = i2c_busy;
    end

    // Reference: walk the table from address 0 until FF or the last address.
    task automatic build_expected();
        exp_q.delete();
        exp_end = 255;
        for (int a = 0; a < 256; a++) begin
            if (rom[a][15:8] == 8'hFF) begin
                exp_end = a;
                break;
            end
            if (rom[a][15:8] != 8'hFE) exp_q.push_back({rom[a], 16'h0000});
        end
    endtask

    task automatic fill_random(input int n);
        int k;
        for (int a = 0; a < 256; a++) rom[a] = 16'($urandom);
        for (int a = 0; a < n; a++) begin
            k = $urandom_range(0, 9);
            if (k == 8)      rom[a] = 16'hFE00;
            else if (k == 9) rom[a] = 16'hFE01;
            else             rom[a] = {8'($urandom_range(0, 253)), 8'($urandom)};
        end
    endtask

    task automatic run_table(input int budget);
        int k;
        pulse_q.delete();
        pulse_cyc_q.delete();
        fall_q.delete();
        @(negedge clk);
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!(done || err) && k < budget) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (!(done || err)) begin
            errors++;
            $display("FAIL run_end_timeout: no done/err after %0d cycles, want done or err", k);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({tbl_addr, i2c_wr, i2c_rd, i2c_wr_data, run, done, err, wr_count} !== '0) begin
            errors++;
            $display("FAIL reset_values: addr=%0h wr=%b rd=%b data=%h run=%b done=%b err=%b cnt=%0d want all 0",
                     tbl_addr, i2c_wr, i2c_rd, i2c_wr_data, run, done, err, wr_count);
        end
        checks++;
        if (i2c_adr !== 7'h21 || i2c_wr_bytes !== 3'd2) begin
            errors++;
            $display("FAIL const_outputs: adr=%h bytes=%0d want 21/2", i2c_adr, i2c_wr_bytes);
        end
    endtask

    task automatic test_basic();
        for (int a = 0; a < 256; a++) rom[a] = 16'hFF00;
        rom[0] = 16'h1280;
        rom[1] = 16'h1101;
        rom[2] = {8'hFF, 8'($urandom)};
        busy_never = 1'b0;
        busy_len   = 50;
        run_table(5000);
        checks++;
        if (pulse_q.size() != 2) begin
            errors++;
            $display("FAIL basic_pulses: got %0d want 2", pulse_q.size());
        end else begin
            checks++;
            if (pulse_q[0] !== 32'h12800000 || pulse_q[1] !== 32'h11010000) begin
                errors++;
                $display("FAIL basic_data: got %h %h want 12800000 11010000", pulse_q[0], pulse_q[1]);
            end
            checks++;
            if (pulse_cyc_q[0] != start_cyc + 3) begin
                errors++;
                $display("FAIL basic_latency: pulse at %0d want %0d", pulse_cyc_q[0], start_cyc + 3);
            end
            checks++;
            if (fall_q.size() < 1 || pulse_cyc_q[1] < fall_q[0] + int'(GAP) + 3) begin
                errors++;
                $display("FAIL basic_gap: second pulse at %0d want >= busy-low %0d + %0d",
                         pulse_cyc_q[1], (fall_q.size() > 0) ? fall_q[0] : -1, GAP + 3);
            end
        end
        checks++;
        if (done !== 1'b1 || err !== 1'b0 || run !== 1'b0 || wr_count !== 8'd2) begin
            errors++;
            $display("FAIL basic_status: done=%b err=%b run=%b cnt=%0d want 1/0/0/2", done, err, run, wr_count);
        end
    endtask

    task automatic test_delay();
        int lat;
        for (int pass = 0; pass < 2; pass++) begin
            rom[0] = (pass == 0) ? 16'hFE03 : 16'hFE00;
            rom[1] = 16'h3A04;
            rom[2] = 16'hFF00;
            busy_len = $urandom_range(1, 8);
            run_table(5000);
            checks++;
            if (pulse_q.size() != 1 || pulse_q[0] !== 32'h3A040000) begin
                errors++;
                $display("FAIL delay_data pass %0d: got %0d pulses first %h want 1 x 3a040000",
                         pass, pulse_q.size(), (pulse_q.size() > 0) ? pulse_q[0] : 32'h0);
            end else begin
                lat = pulse_cyc_q[0] - (start_cyc + 1);
                checks++;
                if ((pass == 0 && (lat < 3 * int'(CPM) - 2 || lat > 3 * int'(CPM) + 2)) ||
                    (pass == 1 && lat > 6)) begin
                    errors++;
                    $display("FAIL delay_latency pass %0d: got %0d cycles want %s", pass, lat,
                             (pass == 0) ? "30+-2" : "<=6");
                end
            end
        end
    endtask

    task automatic test_timeout();
        int k;
        int p;
        for (int a = 0; a < 256; a++) rom[a] = 16'hFF00;
        rom[0] = 16'h1280;
        busy_never = 1'b1;
        pulse_q.delete();
        pulse_cyc_q.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!i2c_wr && k < 20) begin
            @(negedge clk);
            k++;
        end
        p = cyc;
        repeat (ACKT - 1) @(negedge clk);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: err=%b at pulse+%0d want 0", err, cyc - p);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || done !== 1'b0 || run !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err: err=%b done=%b run=%b at pulse+%0d want 1/0/0",
                     err, done, run, cyc - p);
        end
        busy_never = 1'b0;
        busy_len   = 4;
        rom[1] = 16'h5566;
        rom[2] = 16'hFF00;
        run_table(5000);
        checks++;
        if (pulse_q.size() != 2 || pulse_q[0] !== 32'h12800000 || done !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_restart: pulses=%0d first=%h done=%b err=%b want 2/12800000/1/0",
                     pulse_q.size(), (pulse_q.size() > 0) ? pulse_q[0] : 32'h0, done, err);
        end
    endtask

    task automatic test_random();
        int n;
        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(1, 12);
            fill_random(n);
            rom[n] = {8'hFF, 8'($urandom)};
            busy_len = $urandom_range(1, 20);
            build_expected();
            run_table(20000);
            checks++;
            if (pulse_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL random_count t%0d: got %0d writes want %0d", t, pulse_q.size(), exp_q.size());
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    checks++;
                    if (pulse_q[i] !== exp_q[i]) begin
                        errors++;
                        $display("FAIL random_data t%0d w%0d: got %h want %h", t, i, pulse_q[i], exp_q[i]);
                    end
                end
            end
            checks++;
            if (done !== 1'b1 || wr_count !== 8'(exp_q.size()) || tbl_addr !== 8'(exp_end)) begin
                errors++;
                $display("FAIL random_status t%0d: done=%b cnt=%0d addr=%0d want 1/%0d/%0d",
                         t, done, wr_count, tbl_addr, exp_q.size(), exp_end);
            end
        end
    endtask

    task automatic test_nowrap();
        fill_random(256);
        busy_len = 2;
        build_expected();
        run_table(40000);
        checks++;
        if (pulse_q.size() != exp_q.size() || tbl_addr !== 8'hFF || done !== 1'b1 ||
            wr_count !== 8'(exp_q.size())) begin
            errors++;
            $display("FAIL nowrap: writes=%0d addr=%0d done=%b cnt=%0d want %0d/255/1/%0d",
                     pulse_q.size(), tbl_addr, done, wr_count, exp_q.size(), 8'(exp_q.size()));
        end
        repeat (50) @(negedge clk);
        checks++;
        if (pulse_q.size() != exp_q.size() || run !== 1'b0) begin
            errors++;
            $display("FAIL nowrap_idle: writes=%0d run=%b want %0d/0", pulse_q.size(), run, exp_q.size());
        end
    endtask

    task automatic test_start_hold();
        int k;
        fill_random(5);
        rom[5] = 16'hFF00;
        busy_len = 10;
        build_expected();
        pulse_q.delete();
        @(negedge clk);
        start = 1'b1;
        k = 0;
        while (pulse_q.size() < 1 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        k = 0;
        while (!done && k < 20000) begin
            @(negedge clk);
            k++;
        end
        repeat (100) @(negedge clk);
        checks++;
        if (pulse_q.size() != exp_q.size() || done !== 1'b1 || run !== 1'b0) begin
            errors++;
            $display("FAIL start_hold: writes=%0d done=%b run=%b want %0d/1/0",
                     pulse_q.size(), done, run, exp_q.size());
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid();
        int k;
        fill_random(4);
        rom[0] = 16'h2233;
        rom[4] = 16'hFF00;
        busy_len = 50;
        build_expected();
        pulse_q.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!i2c_busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        repeat (5) @(negedge clk);
        checks++;
        if (run !== 1'b1 || wr_count !== 8'd1 || i2c_wr_data !== 32'h22330000) begin
            errors++;
            $display("FAIL mid_run_state: run=%b cnt=%0d data=%h want 1/1/22330000", run, wr_count, i2c_wr_data);
        end
        #1 rstb = 1'b0;
        #1;
        checks++;
        if ({tbl_addr, i2c_wr, i2c_rd, i2c_wr_data, run, done, err, wr_count} !== '0) begin
            errors++;
            $display("FAIL async_reset: addr=%0h wr=%b data=%h run=%b done=%b err=%b cnt=%0d want all 0",
                     tbl_addr, i2c_wr, i2c_wr_data, run, done, err, wr_count);
        end
        @(negedge clk);
        rstb = 1'b1;
        run_table(20000);
        checks++;
        if (pulse_q.size() != exp_q.size() || done !== 1'b1 || wr_count !== 8'(exp_q.size())) begin
            errors++;
            $display("FAIL reset_rerun: writes=%0d done=%b cnt=%0d want %0d/1/%0d",
                     pulse_q.size(), done, wr_count, exp_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (pulse_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL reset_rerun_data w%0d: got %h want %h", i, pulse_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) rom[a] = 16'hFF00;
        repeat (3) @(negedge clk);
        test_reset();
        rstb = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_delay();
        test_timeout();
        test_random();
        test_nowrap();
        test_start_hold();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
